// File: rtl/delay_drain.sv
// rtl/delay_drain.sv - consumer end of an en-gated delay chain with FWFT output FIFO and flush
module delay_drain #(
  parameter int DATA_WIDTH = 864,
  parameter int DELAY_DEEP = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] pipe_din,
  output logic                  pipe_en,
  input  logic [DATA_WIDTH-1:0] pipe_dout,
  input  logic                  pipe_valid,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_EXT = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CW-1:0]         count;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DELAY_DEEP-1:0] real_q;
  logic                  en_q;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic room;
  logic pending;
  logic push;
  logic pop;

  // An advance is allowed only if the item it may produce next cycle has a
  // guaranteed FIFO slot; the in-flight advance (en_q) already holds one.
  assign room = ({1'b0, count} + {{CW{1'b0}}, en_q}) < DEPTH_EXT;

  // Real items still sitting in stages that have not reached the output yet.
  // The top flag marks the item at the chain output, which is captured in the
  // cycle right after the advance that put it there, so it never needs a bubble.
  assign pending = |real_q[DELAY_DEEP-2:0];

  // Capture only real items, and only in the cycle after an advance.
  assign push = en_q & pipe_valid & real_q[DELAY_DEEP-1];
  assign pop  = m_valid & m_ready;

  assign m_valid = (count != '0);
  assign m_data  = m_valid ? mem[rd_ptr] : {DATA_WIDTH{1'b1}};

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, chain advance and upstream handshake; no path from m_ready.
  always_comb begin
    state_nxt  = state;
    pipe_en    = 1'b0;
    s_ready    = 1'b0;
    pipe_din   = {DATA_WIDTH{1'b1}};
    flush_done = 1'b0;
    case (state)
      RUN: begin
        pipe_en  = s_valid & room;
        s_ready  = s_valid & room;
        pipe_din = s_data;
        if (flush_req) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        pipe_en = room & pending;
        if (!pending && !en_q) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        flush_done = 1'b1;
        state_nxt  = RUN;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Advance tracker and shadow of which chain stages hold real items.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q   <= 1'b0;
      real_q <= '0;
    end else begin
      en_q <= pipe_en;
      if (pipe_en) begin
        real_q <= {real_q[DELAY_DEEP-2:0], (state == RUN)};
      end
    end
  end

  // FIFO storage; contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pipe_dout;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_drain.sv
// tb/tb_delay_drain.sv - scoreboard bench for delay_drain with a behavioural delay chain
module tb_delay_drain;

  localparam int DW = 864;
  localparam int DD = 4;
  localparam int FD = 8;
  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] pipe_din;
  logic          pipe_en;
  logic [DW-1:0] pipe_dout;
  logic          pipe_valid;
  logic          flush_req;
  logic          flush_done;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  always #5 clk = ~clk;

  delay_drain #(.DATA_WIDTH(DW), .DELAY_DEEP(DD), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .pipe_din   (pipe_din),
    .pipe_en    (pipe_en),
    .pipe_dout  (pipe_dout),
    .pipe_valid (pipe_valid),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
  );

  // Behavioural en-gated delay chain, deliberately not reset.
  logic [DW-1:0] stg [DD];
  logic [DD-1:0] vld = '0;
  always @(posedge clk) begin
    if (pipe_en) begin
      stg[0] <= pipe_din;
      for (int k = 1; k < DD; k++) stg[k] <= stg[k-1];
      vld <= {vld[DD-2:0], 1'b1};
    end
  end
  assign pipe_dout  = stg[DD-1];
  assign pipe_valid = vld[DD-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] sb [$];
  int cyc = 0;
  int pops = 0;
  int accepts = 0;
  int done_cnt = 0;
  int bubbles = 0;
  int flush_s_ready = 0;
  int first_acc = -1;
  int first_mv = -1;
  int last_pop = -1;
  int max_count = 0;
  bit flush_win = 1'b0;
  bit lat_arm = 1'b0;
  bit abort = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard monitor: push on accept, pop and compare on delivery.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (s_valid && s_ready) begin
          sb.push_back(s_data);
          accepts++;
          if (lat_arm && first_acc < 0) first_acc = cyc;
        end
        if (m_valid && lat_arm && first_mv < 0) first_mv = cyc;
        if (m_valid && m_ready) begin
          if (sb.size() == 0) begin
            check("pop_unexpected", m_data, ONES);
          end else begin
            e = sb.pop_front();
            check("m_data", m_data, e);
          end
          pops++;
          last_pop = cyc;
        end
        if (flush_done) done_cnt++;
        if (flush_win && pipe_en) bubbles++;
        if (flush_win && s_ready) flush_s_ready++;
        if (int'(dut.count) > max_count) max_count = int'(dut.count);
      end
    end
  end

  task automatic send_stream(input int n, input int base, input bit do_flush);
    int i = 0;
    int guard = 0;
    bit ok;
    while (i < n && !abort && guard < 2000) begin
      s_data  = DW'(base + i);
      s_valid = 1'b1;
      @(negedge clk);
      ok = s_ready;
      if (ok && do_flush && i == n - 1) flush_req = 1'b1;
      @(posedge clk);
      #1;
      flush_req = 1'b0;
      if (ok) i++;
      guard++;
    end
    s_valid = 1'b0;
    if (!abort) check("stream_done", DW'(i), DW'(n));
  endtask

  task automatic wait_done(input int start_cnt, input int budget);
    int k = 0;
    while (done_cnt <= start_cnt && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("flush_done_pulses", DW'(done_cnt - start_cnt), DW'(1));
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((sb.size() != 0 || m_valid) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_sb_empty", DW'(sb.size()), DW'(0));
    check("drain_m_valid", DW'(m_valid), DW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int d0;
    int a0;
    int k;
    s_valid   = 1'b0;
    s_data    = '0;
    flush_req = 1'b0;
    m_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", DW'(m_valid), DW'(0));
    check("rst_flush_done", DW'(flush_done), DW'(0));
    check("rst_m_data", m_data, ONES);
    check("rst_count", DW'(dut.count), DW'(0));
    check("rst_pipe_en", DW'(pipe_en), DW'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Continuous stream of 20, flush on the last item.
    m_ready   = 1'b1;
    lat_arm   = 1'b1;
    first_acc = -1;
    first_mv  = -1;
    p0 = pops;
    d0 = done_cnt;
    send_stream(20, 0, 1'b1);
    wait_done(d0, 40);
    wait_drain(60);
    lat_arm = 1'b0;
    check("latency", DW'(first_mv - first_acc), DW'(DD + 1));
    check("stream_pops", DW'(pops - p0), DW'(20));
    check("stream_no_gaps", DW'(last_pop - first_mv), DW'(19));

    // Downstream stalled: backpressure at full reservation.
    m_ready = 1'b0;
    a0 = accepts;
    p0 = pops;
    d0 = done_cnt;
    fork
      send_stream(16, 100, 1'b1);
      begin
        repeat (25) @(posedge clk);
        #2;
        check("stall_accepts", DW'(accepts - a0), DW'(FD + DD - 1));
        check("stall_count", DW'(dut.count), DW'(FD));
        check("stall_s_ready", DW'(s_ready), DW'(0));
        check("stall_m_valid", DW'(m_valid), DW'(1));
        check("stall_no_pop", DW'(pops - p0), DW'(0));
        m_ready = 1'b1;
      end
    join
    wait_done(d0, 60);
    wait_drain(60);
    check("stall_pops", DW'(pops - p0), DW'(16));

    // Three items then an explicit flush with upstream still offering data.
    p0 = pops;
    send_stream(3, 200, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    d0 = done_cnt;
    bubbles = 0;
    flush_s_ready = 0;
    flush_win = 1'b1;
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    s_data  = DW'(999);
    s_valid = 1'b1;
    k = 0;
    while (!flush_done && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
    s_valid   = 1'b0;
    flush_win = 1'b0;
    check("flush3_done_seen", DW'(flush_done), DW'(1));
    check("flush3_bubbles", DW'(bubbles), DW'(3));
    check("flush3_s_ready", DW'(flush_s_ready), DW'(0));
    wait_done(d0, 5);
    wait_drain(30);
    check("flush3_pops", DW'(pops - p0), DW'(3));

    // Flush straight after reset with nothing in the chain.
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    p0 = pops;
    d0 = done_cnt;
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    k = 0;
    while (!flush_done && k < 4) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("empty_flush_done", DW'(flush_done), DW'(1));
    check("empty_flush_latency", DW'(k), DW'(1));
    wait_done(d0, 5);
    check("empty_flush_writes", DW'(pops - p0), DW'(0));
    check("empty_flush_m_valid", DW'(m_valid), DW'(0));

    // Full FIFO with m_ready toggling every cycle.
    m_ready = 1'b0;
    max_count = 0;
    p0 = pops;
    d0 = done_cnt;
    fork
      send_stream(30, 400, 1'b1);
      begin
        repeat (20) @(posedge clk);
        #2;
        check("toggle_full", DW'(dut.count), DW'(FD));
        repeat (30) begin
          m_ready = ~m_ready;
          @(posedge clk);
          #2;
        end
        m_ready = 1'b1;
      end
    join
    wait_done(d0, 60);
    wait_drain(60);
    check("toggle_pops", DW'(pops - p0), DW'(30));
    check("toggle_max_count", DW'(max_count <= FD), DW'(1));

    // Asynchronous reset in the middle of a stream.
    m_ready = 1'b0;
    abort = 1'b0;
    fork
      send_stream(12, 500, 1'b0);
      begin
        repeat (7) @(posedge clk);
        #2;
        check("pre_reset_m_valid", DW'(m_valid), DW'(1));
        #1;
        abort = 1'b1;
        rst = 1'b0;
        #1;
        check("async_m_valid", DW'(m_valid), DW'(0));
        check("async_count", DW'(dut.count), DW'(0));
        check("async_m_data", m_data, ONES);
        sb.delete();
      end
    join
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    abort = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    p0 = pops;
    d0 = done_cnt;
    send_stream(6, 600, 1'b1);
    wait_done(d0, 40);
    wait_drain(40);
    check("post_reset_pops", DW'(pops - p0), DW'(6));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
